// File: rtl/data_memory_pkg.sv
// Shared types and limits for the multi-cycle MIPS data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  localparam int MAX_WAIT = 15;

endpackage

// File: rtl/data_memory_if.sv
// req/ready/done bus between the MEM stage (master) and the data memory (slave).
interface data_memory_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  ready, done, rdata, err
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output ready, done, rdata, err
  );
endinterface

// File: rtl/data_memory_lane_align.sv
// Combinational little-endian lane steering: store byte enables/data and load extraction.
// Alignment faults are only flagged when DMEM_ALIGN_CHK_EN is defined.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  dmem_size_e  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  dmem_size_e  w_eff_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // The reserved encoding behaves as a word unless the checker rejects it.
  assign w_eff_size = (i_size == RSVD) ? WORD : i_size;
  assign w_half     = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    w_byte = i_rword[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = i_rword[7:0];
    endcase
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    case (w_eff_size)
      BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_uns & w_byte[7]}}, w_byte};
      end
      HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_uns & w_half[15]}}, w_half};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHK_EN
  assign o_fault = (i_size == RSVD)
                || ((i_size == HALF) && i_addr_lo[0])
                || ((i_size == WORD) && (i_addr_lo != 2'b00));
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: rtl/data_memory.sv
// Multi-cycle byte/half/word data memory with WAIT_STATES (0..MAX_WAIT) extra cycles per access.
// Optional alignment checking is enabled with DMEM_ALIGN_CHK_EN.
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int         DEPTH    = 2 ** (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e       r_state;
  dmem_state_e       w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_uns;
  dmem_size_e        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_direct;
  logic              w_acc_we;
  logic              w_acc_uns;
  dmem_size_e        w_acc_size;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [31:0]       w_acc_wdata;
  logic [ADDR_W-3:0] w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wpos;
  logic [31:0]       w_rdata_ext;
  logic              w_fault;
  logic              w_commit;

  assign w_accept     = bus.req && (r_state != WAIT);
  assign w_enter_resp = (w_next == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RESP: w_next = w_accept ? ((WAIT_STATES > 0) ? WAIT : RESP) : IDLE;
      WAIT:       w_next = (r_cnt == 4'd0) ? RESP : WAIT;
      default:    w_next = IDLE;
    endcase
  end

  // Entering RESP straight from an accept (zero wait states) uses the live request.
  assign w_direct    = (r_state != WAIT);
  assign w_acc_we    = w_direct ? bus.we                 : r_we;
  assign w_acc_uns   = w_direct ? bus.uns                : r_uns;
  assign w_acc_size  = w_direct ? dmem_size_e'(bus.size) : r_size;
  assign w_acc_addr  = w_direct ? bus.addr               : r_addr;
  assign w_acc_wdata = w_direct ? bus.wdata              : r_wdata;
  assign w_idx       = w_acc_addr[ADDR_W-1:2];

  dmem_lane_align u_lane_align (
    .i_size    (w_acc_size),
    .i_addr_lo (w_acc_addr[1:0]),
    .i_uns     (w_acc_uns),
    .i_wdata   (w_acc_wdata),
    .i_rword   (r_mem[w_idx]),
    .o_be      (w_be),
    .o_wdata   (w_wpos),
    .o_rdata   (w_rdata_ext),
    .o_fault   (w_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= BYTE;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_we    <= bus.we;
        r_uns   <= bus.uns;
        r_size  <= dmem_size_e'(bus.size);
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_acc_we || w_fault) ? 32'd0 : w_rdata_ext;
        r_err   <= w_fault;
      end else begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // Stores land on the edge that opens RESP; a reset in progress blocks the write.
  assign w_commit = rst_n && w_enter_resp && w_acc_we && !w_fault;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wpos[8*b +: 8];
      end
    end
  end

  assign bus.ready = (r_state != WAIT);
  assign bus.done  = (r_state == RESP);
  assign bus.rdata = r_rdata;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench: a one-wait-state memory driven from a vector table, plus a
// zero-wait-state memory for back-to-back traffic and a mid-access reset sequence.
module tb_data_memory;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   nChecks = 0;
  int   nErrors = 0;

  data_memory_if #(.ADDR_W(12)) busA ();
  data_memory_if #(.ADDR_W(12)) busB ();

  data_memory #(.ADDR_W(12), .WAIT_STATES(1)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  data_memory #(.ADDR_W(12), .WAIT_STATES(0)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [31:0] expRdata, input logic expErr);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr;
    return v;
  endfunction

  // One access on busA, entered and left at a falling edge. Request fields are
  // scrambled right after the accept so that late input changes would show up.
  task automatic applyStimulus(input vec_t v, output logic [31:0] rd, output logic e, output int lat);
    busA.we    = v.we;
    busA.size  = v.size;
    busA.uns   = v.uns;
    busA.addr  = v.addr;
    busA.wdata = v.wdata;
    busA.req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busA.req   = 1'b0;
    busA.we    = ~v.we;
    busA.size  = v.size ^ 2'b01;
    busA.uns   = ~v.uns;
    busA.addr  = v.addr ^ 12'h0FC;
    busA.wdata = ~v.wdata;
    checkOutput("wait_ready", {31'd0, busA.ready}, 32'd0);
    checkOutput("wait_done", {31'd0, busA.done}, 32'd0);
    lat = 1;
    while (!busA.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = busA.rdata;
    e  = busA.err;
    @(negedge clk);
    checkOutput("pulse_end", {31'd0, busA.done}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          sawDone;

    rst_n = 1'b0;
    busA.req = 1'b0; busA.we = 1'b0; busA.size = 2'b00; busA.uns = 1'b0;
    busA.addr = '0; busA.wdata = '0;
    busB.req = 1'b0; busB.we = 1'b0; busB.size = 2'b00; busB.uns = 1'b0;
    busB.addr = '0; busB.wdata = '0;

    vecs.push_back(mk(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 2'b10, 0, 12'h010, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 12'h013, 32'h0000007F, 32'h0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 12'h010, 32'h0, 32'h7F000000, 0));
    vecs.push_back(mk(0, 2'b00, 0, 12'h013, 32'h0, 32'h0000007F, 0));
    vecs.push_back(mk(1, 2'b00, 0, 12'h013, 32'h00000080, 32'h0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 12'h013, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 2'b00, 1, 12'h013, 32'h0, 32'h00000080, 0));
    vecs.push_back(mk(1, 2'b10, 0, 12'h020, 32'h11223344, 32'h0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 12'h022, 32'h0000A5A5, 32'h0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 12'h020, 32'h0, 32'hA5A53344, 0));
    vecs.push_back(mk(0, 2'b01, 0, 12'h022, 32'h0, 32'hFFFFA5A5, 0));
    vecs.push_back(mk(0, 2'b01, 1, 12'h022, 32'h0, 32'h0000A5A5, 0));
    vecs.push_back(mk(0, 2'b00, 1, 12'h021, 32'h0, 32'h00000033, 0));
    vecs.push_back(mk(1, 2'b01, 0, 12'h020, 32'hFFFFBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 12'h020, 32'h0, 32'hA5A5BEEF, 0));
    vecs.push_back(mk(0, 2'b00, 0, 12'h020, 32'h0, 32'hFFFFFFEF, 0));
    vecs.push_back(mk(1, 2'b10, 0, 12'h060, 32'h55667788, 32'h0, 0));
`ifdef DMEM_ALIGN_CHK_EN
    vecs.push_back(mk(1, 2'b10, 0, 12'h061, 32'hFFFFFFFF, 32'h0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 12'h060, 32'h0, 32'h55667788, 0));
    vecs.push_back(mk(0, 2'b01, 0, 12'h061, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 2'b11, 0, 12'h060, 32'h0, 32'h0, 1));
`else
    vecs.push_back(mk(0, 2'b01, 0, 12'h061, 32'h0, 32'h00007788, 0));
    vecs.push_back(mk(0, 2'b11, 0, 12'h060, 32'h0, 32'h55667788, 0));
    vecs.push_back(mk(1, 2'b10, 0, 12'h061, 32'hAABBCCDD, 32'h0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 12'h060, 32'h0, 32'hAABBCCDD, 0));
`endif

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_readyA", {31'd0, busA.ready}, 32'd1);
    checkOutput("rst_doneA", {31'd0, busA.done}, 32'd0);
    checkOutput("rst_rdataA", busA.rdata, 32'd0);
    checkOutput("rst_errA", {31'd0, busA.err}, 32'd0);
    checkOutput("rst_readyB", {31'd0, busB.ready}, 32'd1);
    checkOutput("rst_doneB", {31'd0, busB.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], rd, e, lat);
      checkOutput($sformatf("lat[%0d]", i), 32'(lat), 32'd2);
      checkOutput($sformatf("rdata[%0d]", i), rd, vecs[i].expRdata);
      checkOutput($sformatf("err[%0d]", i), {31'd0, e}, {31'd0, vecs[i].expErr});
    end

    // Zero wait states: store then load with req held high across both accepts.
    busB.we = 1'b1; busB.size = 2'b10; busB.uns = 1'b0;
    busB.addr = 12'h040; busB.wdata = 32'h12345678; busB.req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_st_done", {31'd0, busB.done}, 32'd1);
    checkOutput("b2b_st_ready", {31'd0, busB.ready}, 32'd1);
    checkOutput("b2b_st_rdata", busB.rdata, 32'd0);
    busB.we = 1'b0; busB.wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_ld_done", {31'd0, busB.done}, 32'd1);
    checkOutput("b2b_ld_ready", {31'd0, busB.ready}, 32'd1);
    checkOutput("b2b_ld_rdata", busB.rdata, 32'h12345678);
    busB.req = 1'b0;
    @(negedge clk);
    checkOutput("b2b_idle_done", {31'd0, busB.done}, 32'd0);
    checkOutput("b2b_idle_rdata", busB.rdata, 32'd0);

    // Reset during the wait state of a store must drop it without a done pulse.
    applyStimulus(mk(1, 2'b10, 0, 12'h050, 32'h0, 32'h0, 0), rd, e, lat);
    busA.we = 1'b1; busA.size = 2'b10; busA.uns = 1'b0;
    busA.addr = 12'h050; busA.wdata = 32'hCAFEBABE; busA.req = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    busA.req = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'd0, busA.ready}, 32'd1);
    checkOutput("mid_rst_done", {31'd0, busA.done}, 32'd0);
    checkOutput("mid_rst_rdata", busA.rdata, 32'd0);
    checkOutput("mid_rst_err", {31'd0, busA.err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busA.done) sawDone++;
    end
    checkOutput("mid_rst_no_done", 32'(sawDone), 32'd0);
    applyStimulus(mk(0, 2'b10, 0, 12'h050, 32'h0, 32'h0, 0), rd, e, lat);
    checkOutput("mid_rst_lat", 32'(lat), 32'd2);
    checkOutput("mid_rst_reload", rd, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
